bsa_operand_feeder: RTL and testbench

//  Operand queue directly upstream of the 4-bit bit-serial adder. Buffers up to

---
 rtl/bsa_pkg.sv | 12 +
 rtl/bsa_pair_mem.sv | 33 +++
 rtl/bsa_operand_feeder.sv | 112 +++++++++++
 tb/tb_bsa_operand_feeder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bsa_pkg.sv
// Shared types for the bit-serial adder operand path.
// Holds the operand width and the (a,b) pair bundle.
package bsa_pkg;

  localparam int BSA_WIDTH = 4;

  typedef struct packed {
    logic [BSA_WIDTH-1:0] a;
    logic [BSA_WIDTH-1:0] b;
  } bsa_pair_t;

endpackage

// File: rtl/bsa_pair_mem.sv
// Pair storage for the operand feeder: DEPTH x bsa_pair_t,
// one synchronous write port, one asynchronous read port.
module bsa_pair_mem
  import bsa_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [PW-1:0]   waddr_i,
  input  bsa_pair_t       wdata_i,
  input  logic [PW-1:0]   raddr_i,
  output bsa_pair_t       rdata_o
);

  bsa_pair_t mem_q [DEPTH];

  // Entries are cleared on reset so the read port shows zeros when empty
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bsa_operand_feeder.sv
// Operand queue feeding the 4-bit bit-serial adder.
// Optional FEEDER_STATS_EN adds issue_cnt and hwm outputs.
module bsa_operand_feeder
  import bsa_pkg::*;
#(
  parameter int WIDTH = BSA_WIDTH,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_a,
  input  logic [WIDTH-1:0] push_b,
  output logic             push_ready,
  output logic             add_valid,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic             add_ready,
  output logic [LW-1:0]    level
`ifdef FEEDER_STATS_EN
  ,
  output logic [15:0]      issue_cnt,
  output logic [LW-1:0]    hwm
`endif
);

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop;
  bsa_pair_t     wdata, rdata;

  // Full/empty are derived from the occupancy count only
  assign push_ready = (level_q != LW'(DEPTH));
  assign add_valid  = (level_q != '0);
  assign level      = level_q;

  assign push = push_valid && push_ready;
  assign pop  = add_valid && add_ready;

  assign wdata.a = push_a;
  assign wdata.b = push_b;
  assign add_a   = rdata.a;
  assign add_b   = rdata.b;

  bsa_pair_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (push),
    .waddr_i (wr_q),
    .wdata_i (wdata),
    .raddr_i (rd_q),
    .rdata_o (rdata)
  );

  // Pointer and occupancy next-state
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Queue state register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

`ifdef FEEDER_STATS_EN
  logic [15:0]   issue_q, issue_d;
  logic [LW-1:0] hwm_q, hwm_d;

  // Pop counter wraps freely; watermark follows the new level
  always_comb begin
    issue_d = pop ? issue_q + 16'd1 : issue_q;
    hwm_d   = (level_d > hwm_q) ? level_d : hwm_q;
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_q <= '0;
      hwm_q   <= '0;
    end else begin
      issue_q <= issue_d;
      hwm_q   <= hwm_d;
    end
  end

  assign issue_cnt = issue_q;
  assign hwm       = hwm_q;
`endif

endmodule

// File: tb/tb_bsa_operand_feeder.sv
// Scoreboard bench for the operand feeder with a small
// behavioural 5-cycle adder model hung off the issue side.
module tb_bsa_operand_feeder;
  import bsa_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       push_valid;
  logic [3:0] push_a, push_b;
  logic       push_ready;
  logic       add_valid;
  logic [3:0] add_a, add_b;
  logic       add_ready;
  logic       ar_q;
  logic [2:0] level;
`ifdef FEEDER_STATS_EN
  logic [15:0] issue_cnt;
  logic [2:0]  hwm;
`endif

  int total = 0;
  int bad   = 0;

  bsa_pair_t  exp_q [$];
  logic [3:0] yexp [$];

  logic       use_adder = 1'b0;
  int         busy = 0;
  logic [3:0] sum_q = '0;
  logic [3:0] y_out = '0;
  logic       y_valid = 1'b0;

  always #5 clk = ~clk;

  assign add_ready = use_adder ? (busy == 0) : ar_q;

  bsa_operand_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_a     (push_a),
    .push_b     (push_b),
    .push_ready (push_ready),
    .add_valid  (add_valid),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_ready  (add_ready),
    .level      (level)
`ifdef FEEDER_STATS_EN
    ,
    .issue_cnt  (issue_cnt),
    .hwm        (hwm)
`endif
  );

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  // Adder model: accepts when idle, busy 4 more cycles, then y_out
  always @(posedge clk) begin
    y_valid <= 1'b0;
    if (rst) begin
      busy <= 0;
    end else if (busy == 0) begin
      if (use_adder && add_valid) begin
        sum_q <= add_a + add_b;
        busy  <= 4;
      end
    end else begin
      busy <= busy - 1;
      if (busy == 1) begin
        y_valid <= 1'b1;
        y_out   <= sum_q;
      end
    end
  end

  // Monitor: checks presented operands (every cycle, so stalls
  // prove hold) and pops the scoreboard on an issue
  always @(negedge clk) begin
    if (!rst) begin
      if (add_valid) begin
        if (exp_q.size() == 0) begin
          chk("issue_unexpected", 16'd1, 16'd0);
        end else begin
          chk("add_a", {12'd0, add_a}, {12'd0, exp_q[0].a});
          chk("add_b", {12'd0, add_b}, {12'd0, exp_q[0].b});
          if (add_ready) void'(exp_q.pop_front());
        end
      end
      if (y_valid) begin
        if (yexp.size() == 0) begin
          chk("y_unexpected", 16'd1, 16'd0);
        end else begin
          chk("y_out", {12'd0, y_out}, {12'd0, yexp[0]});
          void'(yexp.pop_front());
        end
      end
    end
  end

  task automatic step(input logic pv, input logic [3:0] a,
                      input logic [3:0] b, input logic ar);
    bsa_pair_t p;
    push_valid = pv;
    push_a     = a;
    push_b     = b;
    ar_q       = ar;
    @(negedge clk);
    if (pv && push_ready && !rst) begin
      p.a = a;
      p.b = b;
      exp_q.push_back(p);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    push_valid = 1'b0;
    push_a     = '0;
    push_b     = '0;
    ar_q       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_level", {13'd0, level}, 16'd0);
    chk("rst_push_ready", {15'd0, push_ready}, 16'd1);
    chk("rst_add_valid", {15'd0, add_valid}, 16'd0);
    chk("rst_add_a", {12'd0, add_a}, 16'd0);
    chk("rst_add_b", {12'd0, add_b}, 16'd0);

    // single push then pop
    step(1'b1, 4'd3, 4'd5, 1'b1);
    chk("t1_valid", {15'd0, add_valid}, 16'd1);
    chk("t1_level", {13'd0, level}, 16'd1);
    step(1'b0, 4'd0, 4'd0, 1'b1);
    chk("t1_level_pop", {13'd0, level}, 16'd0);
    chk("t1_valid_pop", {15'd0, add_valid}, 16'd0);

    // fill while stalled
    step(1'b1, 4'd1, 4'd2, 1'b0);
    step(1'b1, 4'd4, 4'd4, 1'b0);
    step(1'b1, 4'd7, 4'd8, 1'b0);
    step(1'b1, 4'd9, 4'd6, 1'b0);
    chk("t2_level_full", {13'd0, level}, 16'd4);
    chk("t2_push_ready", {15'd0, push_ready}, 16'd0);
    step(1'b1, 4'd11, 4'd11, 1'b0);
    chk("t2_no_5th", {13'd0, level}, 16'd4);
    step(1'b0, 4'd0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b0);

    // full: push with concurrent pop is refused, then taken
    step(1'b1, 4'd5, 4'd5, 1'b1);
    chk("t3_level_3", {13'd0, level}, 16'd3);
    chk("t3_ready", {15'd0, push_ready}, 16'd1);
    step(1'b1, 4'd5, 4'd5, 1'b0);
    chk("t3_level_4", {13'd0, level}, 16'd4);
    repeat (5) step(1'b0, 4'd0, 4'd0, 1'b1);
    chk("t3_drained", {13'd0, level}, 16'd0);

    // steady push+pop at level 2 across pointer wrap
    step(1'b1, 4'd1, 4'd1, 1'b0);
    step(1'b1, 4'd2, 4'd3, 1'b0);
    chk("t4_level_2", {13'd0, level}, 16'd2);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'(i + 3), 4'(15 - i), 1'b1);
      chk("t4_level_hold", {13'd0, level}, 16'd2);
    end
    repeat (2) step(1'b0, 4'd0, 4'd0, 1'b1);
    chk("t4_drained", {13'd0, level}, 16'd0);

    // chained with the adder model
    use_adder = 1'b1;
    yexp.push_back(4'd0);
    yexp.push_back(4'd15);
    yexp.push_back(4'd4);
    step(1'b1, 4'd15, 4'd1, 1'b0);
    step(1'b1, 4'd6, 4'd9, 1'b0);
    step(1'b1, 4'd2, 4'd2, 1'b0);
    for (int i = 0; i < 40 && yexp.size() != 0; i++) begin
      step(1'b0, 4'd0, 4'd0, 1'b0);
    end
    chk("t5_y_timeout", 16'(yexp.size()), 16'd0);
    chk("t5_level", {13'd0, level}, 16'd0);
    use_adder = 1'b0;

    // reset mid-stall
    step(1'b1, 4'd3, 4'd3, 1'b0);
    step(1'b1, 4'd4, 4'd4, 1'b0);
    step(1'b1, 4'd6, 4'd6, 1'b0);
    chk("t6_level_3", {13'd0, level}, 16'd3);
`ifdef FEEDER_STATS_EN
    chk("t6_issue_cnt", issue_cnt, 16'd19);
    chk("t6_hwm", {13'd0, hwm}, 16'd4);
`endif
    rst = 1'b1;
    step(1'b1, 4'd9, 4'd9, 1'b1);
    rst = 1'b0;
    exp_q.delete();
    chk("t6_level_0", {13'd0, level}, 16'd0);
    chk("t6_valid_0", {15'd0, add_valid}, 16'd0);
    chk("t6_ready_1", {15'd0, push_ready}, 16'd1);
`ifdef FEEDER_STATS_EN
    chk("t6_issue_rst", issue_cnt, 16'd0);
    chk("t6_hwm_rst", {13'd0, hwm}, 16'd0);
`endif
    step(1'b0, 4'd0, 4'd0, 1'b0);
    chk("sb_empty", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
